instruction_memory_loader: RTL and testbench

Byte-stream program loader that writes instruction words into the instruction memory and holds the CPU core in reset until a complete program has been written. It sits between an external byte source (UART receiver, JTAG bridge or testbench) and the write port of the instruction memory. It is the writer side of the instruction memory; the core remains its only reader. It gates the core's reset so the core fetches only from a fully loaded image.

---
 rtl/instruction_memory_loader.sv | 152 +++++++++++++++
 tb/tb_instruction_memory_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader
//   Byte-stream program loader. Receives a little-endian 16-bit word count N
//   followed by N instruction words (INST_W/8 bytes each, LSB first), writes
//   them to the instruction memory write port, and holds the core in reset
//   until a complete image has been written.
//
// Ports
//   clk               system clock, rising edge
//   reset_n           asynchronous active-low reset
//   load_start        single-cycle request to begin a load (IDLE/DONE/ERROR only)
//   rx_data/rx_valid  incoming byte stream
//   rx_ready          byte accepted on cycles where rx_valid && rx_ready
//   imem_write_addr   instruction memory write address
//   imem_write_data   instruction word to write
//   imem_write_enable one-cycle write strobe per word
//   core_reset_n      active-low core reset, released only after a good load
//   busy/done/error   load status
module instruction_memory_loader #(
  parameter int INST_W         = 16,
  parameter int I_ADDR_W       = 12,
  parameter int I_MEMORY_DEPTH = 1 << I_ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_start,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [I_ADDR_W-1:0] imem_write_addr,
  output logic [INST_W-1:0]   imem_write_data,
  output logic                imem_write_enable,
  output logic                core_reset_n,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int BYTES = INST_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [31:0]     DEPTH_U   = 32'(I_MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_INST, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [15:0]         len;
  logic [15:0]         word_cnt;
  logic [I_ADDR_W-1:0] addr;
  logic [BC_W-1:0]     byte_cnt;
  logic [INST_W-1:0]   word_buf;
  logic                accept;
  logic [15:0]         len_rx;
  logic                last_word;

  assign accept    = rx_valid && rx_ready;
  // Full length as it will be once the high byte currently on rx_data lands.
  assign len_rx    = {rx_data, len[7:0]};
  assign last_word = (word_cnt == len - 16'd1);

  assign imem_write_addr = addr;
  assign imem_write_data = word_buf;

  always_comb begin
    state_nxt         = state;
    rx_ready          = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    error             = 1'b0;
    core_reset_n      = 1'b0;
    imem_write_enable = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (len_rx == 16'd0)                 state_nxt = S_DONE;
          else if ({16'd0, len_rx} > DEPTH_U)  state_nxt = S_ERROR;
          else                                 state_nxt = S_INST;
        end
      end
      S_INST: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept && byte_cnt == LAST_BYTE) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy              = 1'b1;
        imem_write_enable = 1'b1;
        state_nxt         = last_word ? S_DONE : S_INST;
      end
      S_DONE: begin
        done         = 1'b1;
        core_reset_n = 1'b1;
        if (load_start) state_nxt = S_LEN_LO;
      end
      S_ERROR: begin
        error = 1'b1;
        if (load_start) state_nxt = S_LEN_LO;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      len      <= '0;
      word_cnt <= '0;
      addr     <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            word_cnt <= '0;
            addr     <= '0;
            byte_cnt <= '0;
          end
        end
        S_LEN_LO: if (accept) len[7:0]  <= rx_data;
        S_LEN_HI: if (accept) len[15:8] <= rx_data;
        S_INST: begin
          if (accept) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BC_W'(1);
          end
        end
        S_WRITE: begin
          // Address holds at N-1 after the final word instead of stepping past it.
          if (!last_word) begin
            word_cnt <= word_cnt + 16'd1;
            addr     <= addr + I_ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed self-checking bench for instruction_memory_loader (INST_W=16,
// I_ADDR_W=12). Writes observed on the memory port are logged by a monitor
// and compared against hand-computed expected (address, data) pairs.
module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [11:0] imem_write_addr;
  logic [15:0] imem_write_data;
  logic        imem_write_enable;
  logic        core_reset_n;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [11:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];

  instruction_memory_loader #(
    .INST_W(16),
    .I_ADDR_W(12)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .load_start(load_start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .imem_write_addr(imem_write_addr),
    .imem_write_data(imem_write_data),
    .imem_write_enable(imem_write_enable),
    .core_reset_n(core_reset_n),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_write_enable === 1'b1) begin
      wa.push_back(imem_write_addr);
      wd.push_back(imem_write_data);
      wc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  // One-cycle load_start pulse; returns #1 after the sampling edge.
  task automatic start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  // Present a byte until accepted; returns #1 after the accepting edge with rx_valid still high.
  task automatic send_byte(input logic [7:0] b);
    int unsigned t;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (rx_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("byte_accept", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64 && done !== 1'b1; i++) @(negedge clk);
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_we"},       {31'd0, imem_write_enable}, 32'd0);
    check({tag, "_busy"},     {31'd0, busy}, 32'd0);
    check({tag, "_done"},     {31'd0, done}, 32'd0);
    check({tag, "_error"},    {31'd0, error}, 32'd0);
    check({tag, "_core_rst"}, {31'd0, core_reset_n}, 32'd0);
    check({tag, "_addr"},     {20'd0, imem_write_addr}, 32'd0);
    check({tag, "_data"},     {16'd0, imem_write_data}, 32'd0);
  endtask

  initial begin
    logic [7:0] s3 [8];
    s3 = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};

    reset_n    = 1'b0;
    load_start = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("in_reset");
    reset_n  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (4) @(negedge clk);
    check("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("idle_core_rst", {31'd0, core_reset_n}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_writes", wa.size(), 32'd0);
    rx_valid = 1'b0;

    // Three-word back-to-back load
    clear_log();
    start();
    check("start_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_byte(s3[i]);
    rx_valid = 1'b0;
    @(negedge clk);
    check("w3_we", {31'd0, imem_write_enable}, 32'd1);
    check("w3_addr", {20'd0, imem_write_addr}, 32'd2);
    check("w3_data", {16'd0, imem_write_data}, 32'h9ABC);
    check("w3_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("w3_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("w3_we_off", {31'd0, imem_write_enable}, 32'd0);
    check("w3_done", {31'd0, done}, 32'd1);
    check("w3_core_rst", {31'd0, core_reset_n}, 32'd1);
    check("w3_busy", {31'd0, busy}, 32'd0);
    check("w3_count", wa.size(), 32'd3);
    if (wa.size() == 3) begin
      check("w3_a0", {20'd0, wa[0]}, 32'd0);
      check("w3_d0", {16'd0, wd[0]}, 32'h1234);
      check("w3_a1", {20'd0, wa[1]}, 32'd1);
      check("w3_d1", {16'd0, wd[1]}, 32'h5678);
      check("w3_a2", {20'd0, wa[2]}, 32'd2);
      check("w3_d2", {16'd0, wd[2]}, 32'h9ABC);
      check("w3_gap01", wc[1] - wc[0], 32'd3);
      check("w3_gap12", wc[2] - wc[1], 32'd3);
    end

    // Throttled source: garbage on rx_data while rx_valid is low
    clear_log();
    start();
    check("thr_core_rst", {31'd0, core_reset_n}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_byte(s3[i]);
      rx_valid = 1'b0;
      rx_data  = 8'hFF;
      repeat (5) @(posedge clk);
      #1;
    end
    wait_done("thr_done");
    check("thr_count", wa.size(), 32'd3);
    if (wa.size() == 3) begin
      check("thr_d0", {16'd0, wd[0]}, 32'h1234);
      check("thr_d1", {16'd0, wd[1]}, 32'h5678);
      check("thr_a2", {20'd0, wa[2]}, 32'd2);
      check("thr_d2", {16'd0, wd[2]}, 32'h9ABC);
    end

    // Oversize length 4097, then a good one-word load from ERROR
    clear_log();
    start();
    send_byte(8'h01);
    send_byte(8'h10);
    rx_valid = 1'b0;
    @(negedge clk);
    check("ovr_error", {31'd0, error}, 32'd1);
    check("ovr_core_rst", {31'd0, core_reset_n}, 32'd0);
    check("ovr_busy", {31'd0, busy}, 32'd0);
    check("ovr_rx_ready", {31'd0, rx_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("ovr_writes", wa.size(), 32'd0);
    start();
    check("ovr_error_clr", {31'd0, error}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hEF);
    send_byte(8'hBE);
    rx_valid = 1'b0;
    wait_done("beef_done");
    check("beef_count", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      check("beef_a", {20'd0, wa[0]}, 32'd0);
      check("beef_d", {16'd0, wd[0]}, 32'hBEEF);
    end

    // Zero length, reload from DONE, load_start ignored while busy
    clear_log();
    start();
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_core_rst", {31'd0, core_reset_n}, 32'd1);
    check("zero_writes", wa.size(), 32'd0);
    start();
    check("reload_core_rst", {31'd0, core_reset_n}, 32'd0);
    check("reload_done", {31'd0, done}, 32'd0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    rx_valid = 1'b0;
    start();
    check("busy_start_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    rx_valid = 1'b0;
    wait_done("busy_start_done");
    check("busy_start_count", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      check("busy_start_d0", {16'd0, wd[0]}, 32'h2211);
      check("busy_start_a1", {20'd0, wa[1]}, 32'd1);
      check("busy_start_d1", {16'd0, wd[1]}, 32'h4433);
    end

    // Reset asserted inside a WRITE cycle
    clear_log();
    start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    send_byte(8'h12);
    rx_valid = 1'b0;
    check("rstw_we_before", {31'd0, imem_write_enable}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_write");
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-word after 02 00 34, then a fresh load
    start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    rx_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_writes", wa.size(), 32'd0);
    clear_log();
    start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hCD);
    send_byte(8'hAB);
    rx_valid = 1'b0;
    wait_done("abcd_done");
    check("abcd_count", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      check("abcd_a", {20'd0, wa[0]}, 32'd0);
      check("abcd_d", {16'd0, wd[0]}, 32'hABCD);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
